// File: rtl/farrow_pkg.sv
// Shared widths, FSM state type and output rounding for the Farrow interpolator.
// Optional feature: define FARROW_SAT_EN to saturate the final output instead of wrapping.
package farrow_pkg;

  localparam int unsigned DATA_W = 16;  // Q1.15
  localparam int unsigned COEF_W = 18;  // Q2.16
  localparam int unsigned MU_W   = 16;  // Q0.16
  localparam int unsigned ACC_W  = 48;  // Q.31
  localparam int unsigned PROD_W = COEF_W + DATA_W;

  // Q.31 accumulator to Q1.15 output
  localparam int unsigned OUT_SHIFT = 16;

  localparam logic signed [ACC_W-1:0] RND_OFS = ACC_W'(32'sd32768);
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-32'sd32768);

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StHorn,
    StOut
  } state_t;

  function automatic logic [DATA_W-1:0] round_out(input logic signed [ACC_W-1:0] y);
    logic signed [ACC_W-1:0] r;
    r = (y + RND_OFS) >>> OUT_SHIFT;
`ifdef FARROW_SAT_EN
    if (r > OUT_MAX) begin
      r = OUT_MAX;
    end else if (r < OUT_MIN) begin
      r = OUT_MIN;
    end
`endif
    return DATA_W'(r);
  endfunction

endpackage

// File: rtl/farrow_mac.sv
// Shared signed coefficient x sample multiply-accumulate; clear has priority over enable.
module farrow_mac
  import farrow_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_d, acc_q;

  always_comb begin
    prod  = coef * x;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/farrow_interp.sv
// Farrow fractional-delay interpolator: coefficient RAM, sample history and one shared MAC
// evaluating y = sum_k mu^k * v_k by Horner. Define FARROW_SAT_EN for a saturating output.
module farrow_interp
  import farrow_pkg::*;
#(
  parameter int unsigned TAPS   = 12,
  parameter int unsigned DEGREE = 5,
  localparam int unsigned KW     = (DEGREE > 0) ? $clog2(DEGREE + 1) : 1,
  localparam int unsigned TW     = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coef_wr_en,
  input  logic [KW-1:0]     coef_deg,
  input  logic [TW-1:0]     coef_tap,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_wr_ready,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [MU_W-1:0]   s_mu,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
);

  localparam int unsigned NCOEF = (DEGREE + 1) * TAPS;
  localparam int unsigned IW    = $clog2(NCOEF);

  state_t                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [TW-1:0]            t_q, t_d;
  logic [MU_W-1:0]          mu_q, mu_d;
  logic signed [ACC_W-1:0]  y_q, y_d;
  logic                     m_valid_q, m_valid_d;
  logic [DATA_W-1:0]        m_data_q, m_data_d;

  logic signed [DATA_W-1:0] hist_q [TAPS];
  logic signed [COEF_W-1:0] coef_q [NCOEF];

  logic                     accept, coef_we, mac_clr, mac_en;
  logic [IW-1:0]            rd_idx, wr_idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W+MU_W:0] horn_prod;

  assign coef_wr_ready = (state_q == StIdle);
  // A coefficient write wins over a sample arriving in the same cycle.
  assign s_ready       = coef_wr_ready && !coef_wr_en;
  assign accept        = s_valid && s_ready;
  assign coef_we       = coef_wr_en && coef_wr_ready &&
                         (int'(coef_deg) <= DEGREE) && (int'(coef_tap) < TAPS);
  assign wr_idx        = IW'(int'(coef_deg) * TAPS + int'(coef_tap));
  assign rd_idx        = IW'(int'(k_q) * TAPS + int'(t_q));
  assign horn_prod     = y_q * $signed({1'b0, mu_q});

  farrow_mac u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr  (mac_clr),
    .en   (mac_en),
    .coef (coef_q[rd_idx]),
    .x    (hist_q[t_q]),
    .acc  (acc)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    t_d       = t_q;
    mu_d      = mu_q;
    y_d       = y_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          mu_d    = s_mu;
          k_d     = KW'(DEGREE);
          t_d     = '0;
          y_d     = '0;
          mac_clr = 1'b1;
          state_d = StMac;
        end
      end
      StMac: begin
        mac_en = 1'b1;
        if (int'(t_q) == TAPS - 1) begin
          state_d = StHorn;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      StHorn: begin
        y_d     = acc + ACC_W'(horn_prod >>> MU_W);
        mac_clr = 1'b1;
        if (k_q == '0) begin
          m_valid_d = 1'b1;
          m_data_d  = round_out(y_d);
          state_d   = StOut;
        end else begin
          k_d     = k_q - KW'(1);
          t_d     = '0;
          state_d = StMac;
        end
      end
      StOut: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      k_q       <= '0;
      t_q       <= '0;
      mu_q      <= '0;
      y_q       <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      t_q       <= t_d;
      mu_q      <= mu_d;
      y_q       <= y_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) hist_q[i] <= '0;
    end else if (accept) begin
      hist_q[0] <= s_data;
      for (int i = 1; i < TAPS; i++) hist_q[i] <= hist_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCOEF; i++) coef_q[i] <= '0;
    end else if (coef_we) begin
      coef_q[wr_idx] <= coef_data;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_farrow_interp.sv
// Self-checking bench for farrow_interp: directed cases plus random samples vs. an arithmetic model.
module tb_farrow_interp;

  localparam int TAPS   = 12;
  localparam int DEGREE = 5;
  localparam int LAT    = (DEGREE + 1) * (TAPS + 1) + 1;
  localparam logic [17:0] ONE = 18'h10000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        coef_wr_en = 1'b0;
  logic [2:0]  coef_deg = '0;
  logic [3:0]  coef_tap = '0;
  logic [17:0] coef_data = '0;
  logic        coef_wr_ready;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic [15:0] s_mu = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [15:0] m_data;

  int checks = 0;
  int errors = 0;

  longint cm [DEGREE+1][TAPS];
  longint xm [TAPS];

  always #5 clk = ~clk;

  farrow_interp #(.TAPS(TAPS), .DEGREE(DEGREE)) dut (
    .clk           (clk),
    .rst           (rst),
    .coef_wr_en    (coef_wr_en),
    .coef_deg      (coef_deg),
    .coef_tap      (coef_tap),
    .coef_data     (coef_data),
    .coef_wr_ready (coef_wr_ready),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_mu          (s_mu),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k <= DEGREE; k++) for (int t = 0; t < TAPS; t++) cm[k][t] = 0;
    for (int t = 0; t < TAPS; t++) xm[t] = 0;
  endfunction

  // y = sum_k mu^k v_k via Horner with floor on each mu multiply, then round to Q1.15.
  function automatic logic [15:0] model_out(input logic [15:0] mu);
    longint y, v, r;
    y = 0;
    for (int k = DEGREE; k >= 0; k--) begin
      v = 0;
      for (int t = 0; t < TAPS; t++) v += cm[k][t] * xm[t];
      y = ((y * longint'(mu)) >>> 16) + v;
    end
    r = (y + 32768) >>> 16;
`ifdef FARROW_SAT_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_wr_ready", coef_wr_ready, 1);
  endtask

  task automatic write_coef(input int k, input int t, input logic [17:0] d);
    @(negedge clk);
    coef_wr_en = 1'b1;
    coef_deg   = 3'(k);
    coef_tap   = 4'(t);
    coef_data  = d;
    if (k <= DEGREE && t < TAPS) cm[k][t] = longint'($signed(d));
    @(negedge clk);
    coef_wr_en = 1'b0;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] mu, output logic [15:0] got);
    logic [15:0] exp;
    int lat;
    @(negedge clk);
    check("s_ready_idle", s_ready, 1);
    s_valid = 1'b1;
    s_data  = x;
    s_mu    = mu;
    for (int t = TAPS - 1; t > 0; t--) xm[t] = xm[t-1];
    xm[0] = longint'($signed(x));
    exp = model_out(mu);
    @(negedge clk);
    s_valid = 1'b0;
    lat = 1;
    while (!m_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(LAT));
    check("m_data_model", m_data, exp);
    got = m_data;
    if (m_ready) begin
      @(negedge clk);
      check("m_valid_drop", m_valid, 0);
    end
  endtask

  initial begin
    logic [15:0] got, held;
    do_reset();

    // 1: unit tap, out-of-range writes must not alias into other rows
    write_coef(0, 0, ONE);
    write_coef(0, 12, ONE);
    write_coef(6, 0, ONE);
    send(16'h4000, 16'h1234, got);
    check("t1_unit", got, 16'h4000);

    // 2: first-order branch only
    do_reset();
    write_coef(1, 0, ONE);
    send(16'h4000, 16'h8000, got);
    check("t2_mu_half", got, 16'h2000);
    send(16'h4000, 16'h0000, got);
    check("t2_mu_zero", got, 16'h0000);

    // 3: three-tap sum exercises the history shift
    do_reset();
    for (int t = 0; t < 3; t++) write_coef(0, t, ONE);
    send(16'h1000, 16'h0000, got);
    check("t3_s1", got, 16'h1000);
    send(16'h1000, 16'hFFFF, got);
    check("t3_s2", got, 16'h2000);
    send(16'h1000, 16'h5555, got);
    check("t3_s3", got, 16'h3000);

    // 4: output overflow
    do_reset();
    write_coef(0, 0, ONE);
    write_coef(0, 1, ONE);
    send(16'h7000, 16'h0000, got);
    check("t4_s1", got, 16'h7000);
    send(16'h7000, 16'h0000, got);
`ifdef FARROW_SAT_EN
    check("t4_ovf", got, 16'h7FFF);
`else
    check("t4_ovf", got, 16'hE000);
`endif

    // 5: backpressure holds the output and locks out writes
    m_ready = 1'b0;
    send(16'h0800, 16'h0000, held);
    for (int i = 0; i < 20; i++) begin
      coef_wr_en = (i == 5);
      coef_deg   = 3'd0;
      coef_tap   = 4'd0;
      coef_data  = 18'h3FFFF;
      @(negedge clk);
      check("t5_hold_data", m_data, held);
      check("t5_hold_valid", m_valid, 1);
      check("t5_s_ready", s_ready, 0);
      check("t5_wr_ready", coef_wr_ready, 0);
    end
    coef_wr_en = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("t5_release", m_valid, 0);
    send(16'h0100, 16'h0000, got);
    check("t5_write_ignored", got, 16'h0900);

    // 6: reset mid-computation
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 16'h5000;
    s_mu    = 16'h0000;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_abort_valid", m_valid, 0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    check("t6_s_ready", s_ready, 1);
    check("t6_wr_ready", coef_wr_ready, 1);
    write_coef(0, 0, ONE);
    write_coef(0, 1, ONE);
    send(16'h2000, 16'h0000, got);
    check("t6_zero_hist", got, 16'h2000);

    // Random coefficients, samples and delays against the model
    do_reset();
    for (int k = 0; k <= DEGREE; k++) begin
      for (int t = 0; t < TAPS; t++) begin
        logic [17:0] d;
        d = 18'($urandom);
        if (k > 1) d = 18'($signed(d) >>> 3);
        write_coef(k, t, d);
      end
    end
    for (int n = 0; n < 16; n++) begin
      logic [15:0] x, mu;
      x  = 16'($urandom);
      mu = (n == 3) ? 16'hFFFF : (n == 4) ? 16'h0000 : 16'($urandom);
      send(x, mu, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
